// File: rtl/grant_burst_pkg.sv
// grant_burst_pkg
// Shared types, widths and helper functions for the grant burst controller.
//   state_t       : FSM state encoding (IDLE, OWN, GAP)
//   DEF_*         : default parameter values of grant_burst_ctrl
//   BEAT_W        : beat counter width for the default MAX_BURST
//   GAP_W         : gap counter width, sized for the largest legal GAP_CYCLES
//   beat_width()  : beat counter width for any MAX_BURST
//   lowest_set()  : isolate the lowest-index set bit (one-hot result)
//   is_multi_hot(): more than one bit set
package grant_burst_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DEF_N          = 3;
  localparam int DEF_MAX_BURST  = 8;
  localparam int DEF_GAP_CYCLES = 1;
  localparam int MAX_GAP_CYCLES = 15;

  // Helper functions operate on a fixed 32-bit container; callers zero-extend
  // and slice back to their own width.
  localparam int MAX_N = 32;

  localparam int BEAT_W = $clog2(DEF_MAX_BURST + 1);
  localparam int GAP_W  = $clog2(MAX_GAP_CYCLES + 1);

  function automatic int beat_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // x & -x keeps only the lowest set bit.
  function automatic logic [MAX_N-1:0] lowest_set(input logic [MAX_N-1:0] vec);
    return vec & (~vec + {{(MAX_N-1){1'b0}}, 1'b1});
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic is_multi_hot(input logic [MAX_N-1:0] vec);
    return (vec & (vec - {{(MAX_N-1){1'b0}}, 1'b1})) != {MAX_N{1'b0}};
  endfunction

endpackage

// File: rtl/grant_burst_ctrl_onehot_to_index.sv
// onehot_to_index
// Converts a one-hot vector to the binary index of its set bit.
//   onehot : in  N          one-hot (or all-zero) vector
//   index  : out $clog2(N)  index of the set bit; 0 when onehot is all-zero
module onehot_to_index #(
  parameter int N = 3
) (
  input  logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] index
);

  localparam int IW = $clog2(N);

  // OR together the indices of all set bits; exact for a one-hot input.
  always_comb begin
    index = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        index = index | IW'(i);
      end else begin
        index = index;
      end
    end
  end

endmodule

// File: rtl/grant_burst_ctrl.sv
// grant_burst_ctrl
// Turns a one-cycle one-hot arbiter grant into held bus ownership that lasts
// while the winner keeps requesting, capped at MAX_BURST cycles. A capped
// ownership is followed by a GAP_CYCLES idle gap so lower-priority requesters
// can win the next arbitration.
//   clk       : in  1                      system clock, rising edge
//   rst_n     : in  1                      asynchronous active-low reset
//   gnt_in    : in  N                      one-hot grant from the arbiter
//   req_in    : in  N                      raw request lines
//   own       : out N                      registered one-hot ownership
//   owner_id  : out $clog2(N)              index of the owner (0 when idle)
//   busy      : out 1                      ownership active
//   beat_cnt  : out $clog2(MAX_BURST+1)    own cycles so far (0 when idle)
//   timeout   : out 1                      pulse when own drops on MAX_BURST
//   err_multi : out 1                      pulse on multi-hot gnt_in in IDLE
module grant_burst_ctrl #(
  parameter int N          = 3,
  parameter int MAX_BURST  = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N-1:0]                   gnt_in,
  input  logic [N-1:0]                   req_in,
  output logic [N-1:0]                   own,
  output logic [$clog2(N)-1:0]           owner_id,
  output logic                           busy,
  output logic [$clog2(MAX_BURST+1)-1:0] beat_cnt,
  output logic                           timeout,
  output logic                           err_multi
);

  import grant_burst_pkg::*;

  localparam int                BW        = beat_width(MAX_BURST);
  localparam logic [BW-1:0]     BEAT_ONE  = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]     BEAT_MAX  = BW'(MAX_BURST);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_ONE   = {{(GAP_W-1){1'b0}}, 1'b1};

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;

  logic [MAX_N-1:0]   gnt_ext_s;
  logic [MAX_N-1:0]   gnt_low_ext_s;
  logic [N-1:0]       gnt_low_s;
  logic               gnt_multi_s;
  logic               owner_req_s;

  // Priority pick of the incoming grant: bit 0 wins on a multi-hot grant.
  assign gnt_ext_s     = MAX_N'(gnt_in);
  assign gnt_low_ext_s = lowest_set(gnt_ext_s);
  assign gnt_low_s     = gnt_low_ext_s[N-1:0];
  assign gnt_multi_s   = is_multi_hot(gnt_ext_s);

  // own is one-hot, so masking the requests with it yields the owner's request.
  assign owner_req_s = |(req_in & own);

  // Status outputs come only from the own register.
  assign busy = |own;

  onehot_to_index #(.N(N)) u_owner_idx (
    .onehot (own),
    .index  (owner_id)
  );

  // Ownership FSM: grant capture, burst counting, release and post-timeout gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      own       <= {N{1'b0}};
      beat_cnt  <= {BW{1'b0}};
      gap_cnt   <= {GAP_W{1'b0}};
      timeout   <= 1'b0;
      err_multi <= 1'b0;
    end else begin
      timeout   <= 1'b0;
      err_multi <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_in != {N{1'b0}}) begin
            state     <= OWN;
            own       <= gnt_low_s;
            beat_cnt  <= BEAT_ONE;
            err_multi <= gnt_multi_s;
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          // A request drop takes precedence over the burst limit.
          if (!owner_req_s) begin
            state    <= IDLE;
            own      <= {N{1'b0}};
            beat_cnt <= {BW{1'b0}};
          end else if (beat_cnt == BEAT_MAX) begin
            own      <= {N{1'b0}};
            beat_cnt <= {BW{1'b0}};
            timeout  <= 1'b1;
            if (GAP_CYCLES == 0) begin
              state <= IDLE;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end else begin
            beat_cnt <= beat_cnt + BEAT_ONE;
          end
        end
        GAP: begin
          // Leaving on the count of 1 gives GAP_CYCLES cycles in GAP.
          if (gap_cnt <= GAP_ONE) begin
            state   <= IDLE;
            gap_cnt <= {GAP_W{1'b0}};
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          own      <= {N{1'b0}};
          beat_cnt <= {BW{1'b0}};
          gap_cnt  <= {GAP_W{1'b0}};
        end
      endcase
    end
  end

endmodule
